// File: rtl/omr_sheet_loader_if.sv
// Row/sheet handshake bundle between the OMR scan front end, the sheet loader and the scorer.
interface omr_sheet_loader_if;
   logic        sheet_start;
   logic        sheet_abort;
   logic        mark_valid;
   logic [3:0]  mark;
   logic        mark_ready;
   logic [3:0]  mark_index;
   logic [39:0] student_answers;
   logic [9:0]  bad_mask;
   logic [3:0]  blank_count;
   logic [3:0]  multi_count;
   logic        sheet_valid;
   logic        sheet_ack;

   modport master (
      output sheet_start, sheet_abort, mark_valid, mark, sheet_ack,
      input  mark_ready, mark_index, student_answers, bad_mask,
             blank_count, multi_count, sheet_valid
   );

   modport slave (
      input  sheet_start, sheet_abort, mark_valid, mark, sheet_ack,
      output mark_ready, mark_index, student_answers, bad_mask,
             blank_count, multi_count, sheet_valid
   );
endinterface

// File: rtl/omr_sheet_loader.sv
// Assembles ten 4-bit bubble rows into one 40-bit answer sheet and flags rows that are not one-hot.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for sheet_start; last sheet's data still visible
// ST_COLLECT | accepting rows 0..9; sheet_abort returns to ST_IDLE
// ST_DONE    | sheet complete and frozen until sheet_ack
module omr_sheet_loader (
   input logic               clk,
   input logic               reset_n,
   omr_sheet_loader_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t     state;
   logic [5:0] nib_hi;
   logic [3:0] bad_idx;
   logic [2:0] mark_pop;

   // Question 0 lives in the top nibble, so the write position counts down from bit 39.
   assign nib_hi   = 6'd39 - {bus.mark_index, 2'b00};
   assign bad_idx  = 4'd9 - bus.mark_index;
   assign mark_pop = {2'b00, bus.mark[0]} + {2'b00, bus.mark[1]}
                   + {2'b00, bus.mark[2]} + {2'b00, bus.mark[3]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state               <= ST_IDLE;
         bus.mark_ready      <= 1'b0;
         bus.mark_index      <= 4'd0;
         bus.student_answers <= 40'd0;
         bus.bad_mask        <= 10'd0;
         bus.blank_count     <= 4'd0;
         bus.multi_count     <= 4'd0;
         bus.sheet_valid     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.sheet_start) begin
                  state               <= ST_COLLECT;
                  bus.mark_ready      <= 1'b1;
                  bus.mark_index      <= 4'd0;
                  bus.student_answers <= 40'd0;
                  bus.bad_mask        <= 10'd0;
                  bus.blank_count     <= 4'd0;
                  bus.multi_count     <= 4'd0;
               end
            end

            ST_COLLECT: begin
               // Abort takes priority so a row presented in the same cycle is never written.
               if (bus.sheet_abort) begin
                  state          <= ST_IDLE;
                  bus.mark_ready <= 1'b0;
               end else if (bus.mark_valid && bus.mark_ready) begin
                  bus.student_answers[nib_hi -: 4] <= bus.mark;
                  if (mark_pop == 3'd0) begin
                     bus.bad_mask[bad_idx] <= 1'b1;
                     bus.blank_count       <= bus.blank_count + 4'd1;
                  end else if (mark_pop != 3'd1) begin
                     bus.bad_mask[bad_idx] <= 1'b1;
                     bus.multi_count       <= bus.multi_count + 4'd1;
                  end
                  if (bus.mark_index == 4'd9) begin
                     state           <= ST_DONE;
                     bus.mark_index  <= 4'd0;
                     bus.mark_ready  <= 1'b0;
                     bus.sheet_valid <= 1'b1;
                  end else begin
                     bus.mark_index <= bus.mark_index + 4'd1;
                  end
               end
            end

            ST_DONE: begin
               if (bus.sheet_ack) begin
                  state           <= ST_IDLE;
                  bus.sheet_valid <= 1'b0;
               end
            end

            default: begin
               state           <= ST_IDLE;
               bus.mark_ready  <= 1'b0;
               bus.sheet_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_omr_sheet_loader.sv
// Self-checking bench for omr_sheet_loader: directed scenarios plus randomized sheets against a sheet-level model.
module tb_omr_sheet_loader;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   omr_sheet_loader_if bus ();

   omr_sheet_loader dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sheet-level reference: answers in question order, classification by bit count.
   task automatic model(input logic [3:0] r [10], output logic [39:0] ans, output logic [9:0] bad,
                        output logic [3:0] nb, output logic [3:0] nm);
      ans = '0; bad = '0; nb = '0; nm = '0;
      for (int q = 0; q < 10; q++) begin
         ans = {ans[35:0], r[q]};
         if ($countones(r[q]) == 0) begin bad[9-q] = 1'b1; nb = nb + 4'd1; end
         else if ($countones(r[q]) > 1) begin bad[9-q] = 1'b1; nm = nm + 4'd1; end
      end
   endtask

   // Starts a sheet and feeds ten rows; optional random gaps carry junk on mark.
   task automatic feed_sheet(input logic [3:0] r [10], input bit gaps, output int cyc);
      int i;
      @(negedge clk);
      bus.sheet_start = 1'b1;
      @(negedge clk);
      bus.sheet_start = 1'b0;
      cyc = 1;
      i = 0;
      while (i < 10 && cyc < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.mark_valid = 1'b0;
            bus.mark       = 4'($urandom_range(0, 15));
         end else begin
            bus.mark_valid = 1'b1;
            bus.mark       = r[i];
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.mark_valid = 1'b0;
   endtask

   task automatic do_ack();
      bus.sheet_ack = 1'b1;
      @(negedge clk);
      bus.sheet_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.sheet_start = 0; bus.sheet_abort = 0; bus.mark_valid = 0; bus.mark = 0; bus.sheet_ack = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.student_answers !== 40'd0) begin errors++; $display("FAIL reset_answers got %h exp 0", bus.student_answers); end
      checks++; if (bus.bad_mask !== 10'd0) begin errors++; $display("FAIL reset_bad_mask got %b exp 0", bus.bad_mask); end
      checks++; if (bus.blank_count !== 4'd0 || bus.multi_count !== 4'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.blank_count, bus.multi_count); end
      checks++; if (bus.mark_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", bus.mark_index); end
      checks++; if (bus.mark_ready !== 1'b0 || bus.sheet_valid !== 1'b0) begin errors++; $display("FAIL reset_flags got ready=%b valid=%b exp 0/0", bus.mark_ready, bus.sheet_valid); end
   endtask

   task automatic test_clean();
      logic [3:0] r [10];
      int cyc;
      r = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8, 4'h8, 4'h8};
      feed_sheet(r, 1'b0, cyc);
      checks++; if (cyc !== 11 || bus.sheet_valid !== 1'b1) begin errors++; $display("FAIL clean_latency got cyc=%0d valid=%b exp 11/1", cyc, bus.sheet_valid); end
      checks++; if (bus.student_answers !== 40'h1224121888) begin errors++; $display("FAIL clean_answers got %h exp 1224121888", bus.student_answers); end
      checks++; if (bus.bad_mask !== 10'd0 || bus.blank_count !== 4'd0 || bus.multi_count !== 4'd0) begin errors++; $display("FAIL clean_flags got bad=%b blank=%0d multi=%0d exp 0", bus.bad_mask, bus.blank_count, bus.multi_count); end
      checks++; if (bus.mark_ready !== 1'b0 || bus.mark_index !== 4'd0) begin errors++; $display("FAIL clean_done got ready=%b idx=%0d exp 0/0", bus.mark_ready, bus.mark_index); end
      do_ack();
   endtask

   task automatic test_bad_rows();
      logic [3:0] r [10];
      int cyc;
      r = '{4'h0, 4'hF, 4'h3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      feed_sheet(r, 1'b0, cyc);
      checks++; if (bus.student_answers !== 40'h0F31111111) begin errors++; $display("FAIL bad_answers got %h exp 0f31111111", bus.student_answers); end
      checks++; if (bus.bad_mask !== 10'b1110000000) begin errors++; $display("FAIL bad_mask got %b exp 1110000000", bus.bad_mask); end
      checks++; if (bus.blank_count !== 4'd1 || bus.multi_count !== 4'd2) begin errors++; $display("FAIL bad_counts got %0d/%0d exp 1/2", bus.blank_count, bus.multi_count); end
      do_ack();
   endtask

   task automatic test_backpressure();
      logic [3:0] r [10];
      int acc;
      int c;
      r = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8, 4'h8, 4'h8};
      @(negedge clk);
      bus.sheet_start = 1'b1;
      @(negedge clk);
      bus.sheet_start = 1'b0;
      acc = 0;
      c = 0;
      while (acc < 10 && c < 100) begin
         checks++; if (bus.mark_index !== 4'(acc)) begin errors++; $display("FAIL bp_index got %0d exp %0d", bus.mark_index, acc); end
         if (c % 3 == 0) begin
            bus.mark_valid = 1'b1; bus.mark = r[acc]; acc++;
         end else begin
            bus.mark_valid = 1'b0; bus.mark = 4'($urandom_range(0, 15));
         end
         c++;
         @(negedge clk);
      end
      bus.mark_valid = 1'b0;
      checks++; if (bus.sheet_valid !== 1'b1 || bus.student_answers !== 40'h1224121888 || bus.bad_mask !== 10'd0) begin errors++; $display("FAIL bp_result got valid=%b ans=%h bad=%b exp 1/1224121888/0", bus.sheet_valid, bus.student_answers, bus.bad_mask); end
      do_ack();
   endtask

   task automatic test_abort();
      logic [3:0] r [10];
      logic [39:0] ea; logic [9:0] eb; logic [3:0] enb, enm;
      for (int i = 0; i < 10; i++) r[i] = (i < 4) ? 4'($urandom_range(0, 15)) : 4'h0;
      @(negedge clk);
      bus.sheet_start = 1'b1;
      @(negedge clk);
      bus.sheet_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mark_valid = 1'b1; bus.mark = r[i];
         @(negedge clk);
      end
      bus.sheet_abort = 1'b1; bus.mark = 4'hF;
      @(negedge clk);
      bus.sheet_abort = 1'b0; bus.mark_valid = 1'b0;
      model(r, ea, eb, enb, enm);
      checks++; if (bus.mark_ready !== 1'b0 || bus.mark_index !== 4'd4) begin errors++; $display("FAIL abort_state got ready=%b idx=%0d exp 0/4", bus.mark_ready, bus.mark_index); end
      checks++; if (bus.student_answers !== ea || bus.bad_mask !== {eb[9:6], 6'd0}) begin errors++; $display("FAIL abort_partial got %h/%b exp %h/%b", bus.student_answers, bus.bad_mask, ea, {eb[9:6], 6'd0}); end
      repeat (5) begin
         @(negedge clk);
         checks++; if (bus.sheet_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", bus.sheet_valid); end
      end
      bus.sheet_start = 1'b1;
      @(negedge clk);
      bus.sheet_start = 1'b0;
      checks++; if (bus.student_answers !== 40'd0 || bus.bad_mask !== 10'd0 || bus.blank_count !== 4'd0 || bus.multi_count !== 4'd0 || bus.mark_index !== 4'd0 || bus.mark_ready !== 1'b1) begin errors++; $display("FAIL abort_restart got ans=%h bad=%b idx=%0d ready=%b exp cleared/ready", bus.student_answers, bus.bad_mask, bus.mark_index, bus.mark_ready); end
      bus.sheet_abort = 1'b1;
      @(negedge clk);
      bus.sheet_abort = 1'b0;
   endtask

   task automatic test_ack_hold();
      logic [3:0] r [10];
      logic [39:0] ea; logic [9:0] eb; logic [3:0] enb, enm;
      int cyc;
      for (int i = 0; i < 10; i++) r[i] = 4'($urandom_range(0, 15));
      model(r, ea, eb, enb, enm);
      feed_sheet(r, 1'b1, cyc);
      bus.sheet_start = 1'b1; bus.sheet_abort = 1'b1; bus.mark_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.mark = 4'($urandom_range(0, 15));
         @(negedge clk);
         checks++; if (bus.sheet_valid !== 1'b1 || bus.mark_ready !== 1'b0 || bus.student_answers !== ea || bus.bad_mask !== eb || bus.blank_count !== enb || bus.multi_count !== enm || bus.mark_index !== 4'd0) begin errors++; $display("FAIL ack_frozen cyc %0d got v=%b rdy=%b ans=%h bad=%b exp %h/%b", i, bus.sheet_valid, bus.mark_ready, bus.student_answers, bus.bad_mask, ea, eb); end
      end
      bus.sheet_start = 1'b0; bus.sheet_abort = 1'b0; bus.mark_valid = 1'b0;
      bus.sheet_ack = 1'b1;
      @(negedge clk);
      checks++; if (bus.sheet_valid !== 1'b0 || bus.student_answers !== ea || bus.bad_mask !== eb) begin errors++; $display("FAIL ack_release got v=%b ans=%h exp 0/%h", bus.sheet_valid, bus.student_answers, ea); end
      repeat (3) @(negedge clk);
      checks++; if (bus.sheet_valid !== 1'b0 || bus.mark_ready !== 1'b0 || bus.blank_count !== enb || bus.multi_count !== enm) begin errors++; $display("FAIL ack_held got v=%b rdy=%b exp 0/0", bus.sheet_valid, bus.mark_ready); end
      bus.sheet_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] r [10];
      logic [39:0] ea; logic [9:0] eb; logic [3:0] enb, enm;
      int cyc;
      @(negedge clk);
      bus.sheet_start = 1'b1;
      @(negedge clk);
      bus.sheet_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.mark_valid = 1'b1; bus.mark = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      bus.mark_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.student_answers !== 40'd0 || bus.bad_mask !== 10'd0 || bus.blank_count !== 4'd0 || bus.multi_count !== 4'd0 || bus.mark_index !== 4'd0 || bus.mark_ready !== 1'b0 || bus.sheet_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got ans=%h bad=%b idx=%0d rdy=%b exp all 0", bus.student_answers, bus.bad_mask, bus.mark_index, bus.mark_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) r[i] = 4'($urandom_range(0, 15));
      model(r, ea, eb, enb, enm);
      feed_sheet(r, 1'b0, cyc);
      checks++; if (bus.sheet_valid !== 1'b1 || bus.student_answers !== ea || bus.bad_mask !== eb || bus.blank_count !== enb || bus.multi_count !== enm) begin errors++; $display("FAIL rst_recover got v=%b ans=%h bad=%b exp 1/%h/%b", bus.sheet_valid, bus.student_answers, bus.bad_mask, ea, eb); end
      do_ack();
   endtask

   task automatic test_random();
      logic [3:0] r [10];
      logic [39:0] ea; logic [9:0] eb; logic [3:0] enb, enm;
      int cyc;
      for (int s = 0; s < 20; s++) begin
         for (int i = 0; i < 10; i++) r[i] = 4'($urandom_range(0, 15));
         model(r, ea, eb, enb, enm);
         feed_sheet(r, 1'b1, cyc);
         checks++; if (bus.sheet_valid !== 1'b1 || bus.student_answers !== ea || bus.bad_mask !== eb || bus.blank_count !== enb || bus.multi_count !== enm) begin errors++; $display("FAIL rand_sheet %0d got v=%b ans=%h bad=%b b=%0d m=%0d exp %h/%b/%0d/%0d", s, bus.sheet_valid, bus.student_answers, bus.bad_mask, bus.blank_count, bus.multi_count, ea, eb, enb, enm); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_ack();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_clean();
      test_bad_rows();
      test_backpressure();
      test_abort();
      test_ack_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
